// File: rtl/n2tmux_arb_if.sv
// Handshake bundle for n2tmux_arb: N request channels in, one registered word out.
// The master side drives requests and out_ready; the slave side is the mux.
interface n2tmux_arb_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/n2tmux_arb.sv
// Registered N:1 mux with explicit-select or round-robin grant.
// One output word register with a valid/ready handshake on both sides.
module n2tmux_arb #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input logic         clk,
  input logic         reset_n,
  n2tmux_arb_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    gnt;
  logic                gnt_vld;
  logic                can_accept;
  logic [CHANNELS-1:0] ready;
  logic                valid_q;
  logic [WIDTH-1:0]    data_q;
  logic [SEL_W-1:0]    chan_q;
  logic [WIDTH-1:0]    word;

  // Gating with reset_n keeps every in_ready low while reset is held.
  assign can_accept = reset_n && (!valid_q || bus.out_ready);

  always_comb begin
    logic [SEL_W-1:0] idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = rr_ptr;
    if (!bus.mode) begin
      if (int'(bus.sel) < CHANNELS && bus.in_valid[bus.sel]) begin
        gnt     = bus.sel;
        gnt_vld = 1'b1;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = (idx == LAST) ? '0 : idx + SEL_W'(1);
        if (!gnt_vld && bus.in_valid[idx]) begin
          gnt     = idx;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ready[i] = can_accept && gnt_vld && (gnt == SEL_W'(i));
    end
  end

  assign word = bus.in_data[gnt*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      rr_ptr  <= LAST;
    end else if (can_accept) begin
      valid_q <= gnt_vld;
      if (gnt_vld) begin
        data_q <= word;
        chan_q <= gnt;
        if (bus.mode) rr_ptr <= gnt;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
endmodule
